pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 72 +++++++
 tb/tb_pipeline_hazard_controller.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use/branch hazard unit with imem-wait FSM, latched redirect target and stall counter
module pipeline_hazard_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RsDe,
    input  logic [4:0]  RtDe,
    input  logic [4:0]  RtEx,
    input  logic        MemReadEx,
    input  logic        PCsrcEx,
    input  logic [31:0] PCtrgEx,
    input  logic        imem_ready,
    output logic        PCsrcFe,
    output logic [31:0] PCtrgFe,
    output logic        StallFe,
    output logic        StallDe,
    output logic        FlushDe,
    output logic        FlushEx,
    output logic        redir_pend,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, WAIT, REDIR} state_e;
    state_e      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic [15:0] cnt_q, cnt_d;
    logic        loaduse, fstall, redir, stall_fe;
    assign loaduse  = MemReadEx && RtEx != 5'd0 && (RtEx == RsDe || RtEx == RtDe);
    assign redir    = state_q == REDIR;
    assign fstall   = !imem_ready || redir || (state_q == WAIT && PCsrcEx);
    // A taken branch outranks load-use, so loaduse only matters when PCsrcEx is low.
    assign stall_fe = redir ? !imem_ready : (fstall || loaduse) && !PCsrcEx;
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        case (state_q)
            RUN: if (!imem_ready) begin
                state_d = PCsrcEx ? REDIR : WAIT;
                tgt_d   = PCsrcEx ? PCtrgEx : tgt_q;
            end
            WAIT: if (PCsrcEx) begin
                state_d = REDIR;
                tgt_d   = PCtrgEx;
            end else if (imem_ready) begin
                state_d = RUN;
            end
            REDIR: begin
                state_d = imem_ready ? RUN : REDIR;
                tgt_d   = PCsrcEx ? PCtrgEx : tgt_q;
            end
            default: state_d = RUN;
        endcase
    end
    assign cnt_d = (stall_fe && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tgt_q   <= 32'h0;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end
    assign PCsrcFe    = !rst && (redir ? imem_ready : PCsrcEx && !fstall);
    assign PCtrgFe    = rst ? 32'h0 : redir ? tgt_q : PCtrgEx;
    assign StallFe    = !rst && stall_fe;
    assign StallDe    = !rst && loaduse && !PCsrcEx;
    assign FlushDe    = !rst && (PCsrcEx || (redir && imem_ready) || (fstall && !loaduse));
    assign FlushEx    = !rst && (PCsrcEx || loaduse);
    assign redir_pend = !rst && redir;
    assign stall_cnt  = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed and random stimulus against a behavioural hazard-unit model
module tb_pipeline_hazard_controller;
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  RsDe = '0, RtDe = '0, RtEx = '0;
    logic        MemReadEx = 1'b0, PCsrcEx = 1'b0, imem_ready = 1'b1;
    logic [31:0] PCtrgEx = '0;
    logic        PCsrcFe, StallFe, StallDe, FlushDe, FlushEx, redir_pend;
    logic [31:0] PCtrgFe;
    logic [15:0] stall_cnt;
    int          checks = 0, failures = 0;
    bit          m_pend = 0, m_wait = 0;
    logic [31:0] m_tgt = '0;
    int          m_cnt = 0;

    pipeline_hazard_controller dut (
        .clk(clk), .rst(rst), .RsDe(RsDe), .RtDe(RtDe), .RtEx(RtEx),
        .MemReadEx(MemReadEx), .PCsrcEx(PCsrcEx), .PCtrgEx(PCtrgEx), .imem_ready(imem_ready),
        .PCsrcFe(PCsrcFe), .PCtrgFe(PCtrgFe), .StallFe(StallFe), .StallDe(StallDe),
        .FlushDe(FlushDe), .FlushEx(FlushEx), .redir_pend(redir_pend), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs mid-cycle, check comb outputs, step the model at the edge, check the counter.
    task automatic cycle(bit r, logic [4:0] rs, logic [4:0] rt, logic [4:0] rx, bit mr, bit br, logic [31:0] tg, bit rdy);
        bit lu, fst, e_src, e_sf, e_sd, e_fd, e_fe, e_rp;
        logic [31:0] e_trg;
        rst = r; RsDe = rs; RtDe = rt; RtEx = rx; MemReadEx = mr; PCsrcEx = br; PCtrgEx = tg; imem_ready = rdy;
        #1;
        lu    = mr && rx != 0 && (rx == rs || rx == rt);
        fst   = !rdy || m_pend || (m_wait && br);
        e_src = r ? 0 : m_pend ? rdy : (br && !fst);
        e_trg = r ? 32'h0 : m_pend ? m_tgt : tg;
        e_sf  = r ? 0 : m_pend ? !rdy : ((fst || lu) && !br);
        e_sd  = !r && lu && !br;
        e_fd  = !r && (br || (m_pend && rdy) || (fst && !lu));
        e_fe  = !r && (br || lu);
        e_rp  = !r && m_pend;
        chk1("PCsrcFe", PCsrcFe, e_src);
        chk32("PCtrgFe", PCtrgFe, e_trg);
        chk1("StallFe", StallFe, e_sf);
        chk1("StallDe", StallDe, e_sd);
        chk1("FlushDe", FlushDe, e_fd);
        chk1("FlushEx", FlushEx, e_fe);
        chk1("redir_pend", redir_pend, e_rp);
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_wait = 0; m_tgt = 0; m_cnt = 0;
        end else begin
            if (e_sf && m_cnt < 65535) m_cnt++;
            if (m_pend) begin
                if (br) m_tgt = tg;
                if (rdy) m_pend = 0;
            end else if (m_wait) begin
                if (br) begin m_pend = 1; m_wait = 0; m_tgt = tg; end
                else if (rdy) m_wait = 0;
            end else if (!rdy) begin
                if (br) begin m_pend = 1; m_tgt = tg; end
                else m_wait = 1;
            end
        end
        #1;
        chk32("stall_cnt", {16'h0, stall_cnt}, m_cnt);
    endtask

    initial begin
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 0, 1, 32'hDEAD, 0);
        cycle(1, 5, 5, 5, 1, 0, 32'h1234, 1);
        chk32("reset_cnt", {16'h0, stall_cnt}, 0);
        // load-use, then the same with RtEx=0
        cycle(0, 5, 0, 5, 1, 0, 0, 1);
        chk32("lu_cnt", {16'h0, stall_cnt}, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        chk32("lu_r0_cnt", {16'h0, stall_cnt}, 1);
        // branch in RUN, alone and with load-use
        cycle(0, 1, 2, 3, 0, 1, 32'h40, 1);
        cycle(0, 5, 0, 5, 1, 1, 32'h40, 1);
        // imem wait of three cycles
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        chk32("wait_cnt", {16'h0, stall_cnt}, 3);
        // branch during a wait
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 32'h100, 0);
        chk1("redir_latched", redir_pend, 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        chk1("redir_done", redir_pend, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        // reset in REDIR discards the redirect
        cycle(0, 0, 0, 0, 0, 1, 32'h200, 0);
        chk1("redir_pre_rst", redir_pend, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk32("rst_redir_cnt", {16'h0, stall_cnt}, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        // random traffic with small register numbers so hazards collide often
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 99) < 2, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 20,
                  $urandom, $urandom_range(0, 99) < 70);
        // counter saturation
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65540; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk32("sat_cnt", {16'h0, stall_cnt}, 32'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
